mem_stage_ws: RTL and testbench

Parametrised pipeline MEM stage for the MIPS core. It holds a byte-addressable data memory and supports byte, half-word and word loads and stores with sign or zero extension. Store data can be forwarded from the W stage, and memory latency is configurable through wait states with a stall handshake. It owns the M/W pipeline register and replaces the word-only, zero-latency stage.

---
 rtl/mem_stage_ws.sv | 209 ++++++++++++++++++++
 tb/tb_mem_stage_ws.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ws.sv
// MIPS MEM stage: byte-addressable data memory with byte/half/word access,
// W-stage store forwarding, configurable wait states and the M/W register.
module mem_stage_ws #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_m,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        load_signed,
  input  logic [31:0] aluout,
  input  logic [31:0] data2,
  input  logic        fwd_sel,
  input  logic [31:0] fwd_data,
  input  logic [31:0] pc_in,
  input  logic [31:0] pc4_in,
  input  logic [31:0] ir_in,
  output logic        stall,
  output logic        valid_w,
  output logic [31:0] aluout_w,
  output logic [31:0] dmout_w,
  output logic [31:0] pc_w,
  output logic [31:0] pc4_w,
  output logic [31:0] ir_w,
  output logic [1:0]  exc_w
);

  localparam int unsigned IDX_W    = ADDR_W - 2;
  localparam int unsigned DEPTH    = 1 << IDX_W;
  localparam bit          HAS_WAIT = (WAIT_CYCLES != 0);
  localparam logic [2:0]  CNT_INIT = 3'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t      state, state_nx;
  logic [2:0]  cnt, cnt_nx;

  logic [31:0] mem [DEPTH];

  logic [31:0] off;
  logic [31:0] wd;
  logic [1:0]  lane;
  logic [IDX_W-1:0] idx;
  logic        in_range;
  logic        misalign;
  logic        is_mem;
  logic        is_load;
  logic        err;
  logic        acc;
  logic        commit;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rword;
  logic [31:0] ld_val;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Address decode and access classification
  always_comb begin
    off      = aluout - BASE_ADDR;
    lane     = off[1:0];
    idx      = off[ADDR_W-1:2];
    in_range = ((off >> ADDR_W) == 32'd0);
    misalign = 1'b0;
    case (size)
      2'd0:    misalign = 1'b0;
      2'd1:    misalign = off[0];
      default: misalign = (off[1:0] != 2'b00);
    endcase
    is_mem  = mem_read | mem_write;
    is_load = mem_read & ~mem_write;
    err     = valid_m & is_mem & (misalign | ~in_range);
    acc     = valid_m & is_mem & ~err;
    wd      = fwd_sel ? fwd_data : data2;
  end

  // Store lane enables and replicated store data
  always_comb begin
    be    = 4'b1111;
    wdata = wd;
    case (size)
      2'd0: begin
        be    = 4'b0001 << lane;
        wdata = {4{wd[7:0]}};
      end
      2'd1: begin
        be    = off[1] ? 4'b1100 : 4'b0011;
        wdata = {2{wd[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = wd;
      end
    endcase
  end

  // Load lane select and extension
  always_comb begin
    rword   = mem[idx];
    ld_byte = rword[{lane, 3'b000} +: 8];
    ld_half = off[1] ? rword[31:16] : rword[15:0];
    ld_val  = rword;
    case (size)
      2'd0:    ld_val = {{24{load_signed & ld_byte[7]}}, ld_byte};
      2'd1:    ld_val = {{16{load_signed & ld_half[15]}}, ld_half};
      default: ld_val = rword;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // FSM next state
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (HAS_WAIT && acc) begin
          state_nx = BUSY;
          cnt_nx   = CNT_INIT;
        end
      end
      BUSY: begin
        if (cnt == 3'd0) begin
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - 3'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // FSM outputs; stall is forced low while reset is asserted
  always_comb begin
    stall = 1'b0;
    if (reset && HAS_WAIT) begin
      case (state)
        IDLE:    stall = acc;
        BUSY:    stall = (cnt != 3'd0);
        default: stall = 1'b0;
      endcase
    end
  end

  assign commit = acc & ~stall;
  assign we     = commit & mem_write;

  // Data memory, cleared by reset; byte enables preserve untouched lanes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // M/W pipeline register, frozen while stalled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_w  <= 1'b0;
      aluout_w <= '0;
      dmout_w  <= '0;
      pc_w     <= '0;
      pc4_w    <= '0;
      ir_w     <= '0;
      exc_w    <= 2'd0;
    end else if (!stall) begin
      valid_w  <= valid_m;
      aluout_w <= aluout;
      dmout_w  <= (acc && is_load) ? ld_val : '0;
      pc_w     <= pc_in;
      pc4_w    <= pc4_in;
      ir_w     <= ir_in;
      if (err) begin
        exc_w <= mem_write ? 2'd2 : 2'd1;
      end else begin
        exc_w <= 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_ws.sv
// Directed bench for mem_stage_ws: three instances with 0, 3 and 2 wait states
// share stimulus; only the selected instance sees valid_m during an access.
module tb_mem_stage_ws;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd, wr, sg, fs;
  logic [1:0]  sz;
  logic [31:0] a, d2, fd, pc, pc4, ir;

  logic        vm   [3];
  logic        st   [3];
  logic        vw   [3];
  logic [31:0] aluw [3];
  logic [31:0] dm   [3];
  logic [31:0] pcw  [3];
  logic [31:0] pc4w [3];
  logic [31:0] irw  [3];
  logic [1:0]  ex   [3];

  int checks = 0;
  int failures = 0;
  int n, n1, n2;

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_dut
      mem_stage_ws #(
        .ADDR_W      (12),
        .WAIT_CYCLES ((g == 0) ? 0 : ((g == 1) ? 3 : 2)),
        .BASE_ADDR   (32'h0000_0000)
      ) u_dut (
        .clk         (clk),
        .reset       (rst_n),
        .valid_m     (vm[g]),
        .mem_read    (rd),
        .mem_write   (wr),
        .size        (sz),
        .load_signed (sg),
        .aluout      (a),
        .data2       (d2),
        .fwd_sel     (fs),
        .fwd_data    (fd),
        .pc_in       (pc),
        .pc4_in      (pc4),
        .ir_in       (ir),
        .stall       (st[g]),
        .valid_w     (vw[g]),
        .aluout_w    (aluw[g]),
        .dmout_w     (dm[g]),
        .pc_w        (pcw[g]),
        .pc4_w       (pc4w[g]),
        .ir_w        (irw[g]),
        .exc_w       (ex[g])
      );
    end
  endgenerate

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One instruction on instance d; returns the number of stalled cycles.
  task automatic op(input int d, input logic r, input logic w, input logic [1:0] s,
                    input logic sgn, input logic [31:0] addr, input logic [31:0] data,
                    input logic f, input logic [31:0] fdat, output int ns);
    @(negedge clk);
    rd = r; wr = w; sz = s; sg = sgn; a = addr; d2 = data; fs = f; fd = fdat;
    pc = ~addr; pc4 = addr + 32'd4; ir = {addr[15:0], addr[31:16]};
    for (int k = 0; k < 3; k++) vm[k] = (k == d);
    ns = 0;
    #1;
    while (st[d] && ns < 20) begin
      ns++;
      @(negedge clk);
      #1;
    end
    if (ns >= 20) check("stall_timeout", 32'(ns), 32'd0);
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) vm[k] = 1'b0;
  endtask

  initial begin
    rd = 0; wr = 0; sg = 0; fs = 0; sz = 2'd2;
    a = '0; d2 = '0; fd = '0; pc = '0; pc4 = '0; ir = '0;
    for (int k = 0; k < 3; k++) vm[k] = 1'b0;

    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("rst_valid_w", 32'(vw[k]), 32'd0);
      check("rst_dmout_w", dm[k], 32'd0);
      check("rst_exc_w",   32'(ex[k]), 32'd0);
      check("rst_stall",   32'(st[k]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Zero wait states: word, byte and half accesses
    op(0, 0, 1, 2'd2, 0, 32'h10, 32'h1234_5678, 0, 0, n);
    check("w0_sw_ns", 32'(n), 32'd0);
    check("w0_sw_exc", 32'(ex[0]), 32'd0);
    check("w0_sw_valid", 32'(vw[0]), 32'd1);
    op(0, 1, 0, 2'd2, 0, 32'h10, 0, 0, 0, n);
    check("w0_lw", dm[0], 32'h1234_5678);
    check("w0_lw_ns", 32'(n), 32'd0);
    op(0, 0, 1, 2'd0, 0, 32'h13, 32'h0000_00AB, 0, 0, n);
    op(0, 1, 0, 2'd2, 0, 32'h10, 0, 0, 0, n);
    check("sb_word", dm[0], 32'hAB34_5678);
    op(0, 1, 0, 2'd0, 1, 32'h13, 0, 0, 0, n);
    check("lb", dm[0], 32'hFFFF_FFAB);
    op(0, 1, 0, 2'd0, 0, 32'h13, 0, 0, 0, n);
    check("lbu", dm[0], 32'h0000_00AB);
    op(0, 1, 0, 2'd1, 1, 32'h12, 0, 0, 0, n);
    check("lh", dm[0], 32'hFFFF_AB34);
    op(0, 1, 0, 2'd1, 0, 32'h10, 0, 0, 0, n);
    check("lhu_low", dm[0], 32'h0000_5678);

    // Misalignment and out-of-range
    op(0, 0, 1, 2'd1, 0, 32'h11, 32'h0000_FFFF, 0, 0, n);
    check("sh_mis_exc", 32'(ex[0]), 32'd2);
    op(0, 1, 0, 2'd2, 0, 32'h10, 0, 0, 0, n);
    check("sh_mis_unchanged", dm[0], 32'hAB34_5678);
    op(0, 1, 0, 2'd2, 0, 32'h12, 0, 0, 0, n);
    check("lw_mis_exc", 32'(ex[0]), 32'd1);
    check("lw_mis_dm", dm[0], 32'd0);
    check("lw_mis_ns", 32'(n), 32'd0);
    op(0, 0, 1, 2'd2, 0, 32'h1000, 32'hCAFE_F00D, 0, 0, n);
    check("sw_oor_exc", 32'(ex[0]), 32'd2);
    op(0, 1, 0, 2'd2, 0, 32'h0, 0, 0, 0, n);
    check("sw_oor_no_alias", dm[0], 32'd0);
    op(0, 1, 0, 2'd2, 0, 32'h1000, 0, 0, 0, n);
    check("lw_oor_exc", 32'(ex[0]), 32'd1);

    // Half and byte lane preservation
    op(0, 0, 1, 2'd1, 0, 32'h12, 32'h0000_5555, 0, 0, n);
    op(0, 0, 1, 2'd0, 0, 32'h10, 32'h0000_01EE, 0, 0, n);
    op(0, 1, 0, 2'd2, 0, 32'h10, 0, 0, 0, n);
    check("sh_sb_lanes", dm[0], 32'h5555_56EE);

    // Non-memory instruction passes M/W values through
    op(0, 0, 0, 2'd2, 0, 32'h1234_ABCD, 0, 0, 0, n);
    check("pt_alu", aluw[0], 32'h1234_ABCD);
    check("pt_pc", pcw[0], 32'hEDCB_5432);
    check("pt_pc4", pc4w[0], 32'h1234_ABD1);
    check("pt_ir", irw[0], 32'hABCD_1234);
    check("pt_exc", 32'(ex[0]), 32'd0);
    check("pt_dm", dm[0], 32'd0);

    // Bubble carrying a store leaves memory alone
    @(negedge clk);
    wr = 1; rd = 0; sz = 2'd2; a = 32'h10; d2 = 32'h0; fs = 0;
    @(posedge clk);
    #1;
    check("bubble_valid", 32'(vw[0]), 32'd0);
    check("bubble_exc", 32'(ex[0]), 32'd0);
    op(0, 1, 0, 2'd2, 0, 32'h10, 0, 0, 0, n);
    check("bubble_mem", dm[0], 32'h5555_56EE);

    // Forwarding and read+write treated as store
    op(0, 0, 1, 2'd2, 0, 32'h20, 32'h0, 1, 32'hDEAD_BEEF, n);
    op(0, 1, 0, 2'd2, 0, 32'h20, 0, 0, 0, n);
    check("w0_fwd", dm[0], 32'hDEAD_BEEF);
    op(0, 1, 1, 2'd2, 0, 32'h24, 32'h11, 0, 0, n);
    check("rw_dm", dm[0], 32'd0);
    op(0, 1, 0, 2'd2, 0, 32'h24, 0, 0, 0, n);
    check("rw_stored", dm[0], 32'h11);

    // Three wait states
    op(1, 0, 1, 2'd2, 0, 32'h40, 32'hA5A5_A5A5, 0, 0, n1);
    op(1, 0, 1, 2'd2, 0, 32'h44, 32'h5A5A_5A5A, 0, 0, n2);
    check("w3_sw_ns", 32'(n1), 32'd3);
    check("w3_b2b_cycles", 32'(n1 + n2 + 2), 32'd8);
    op(1, 1, 0, 2'd2, 0, 32'h40, 0, 0, 0, n);
    check("w3_lw_ns", 32'(n), 32'd3);
    check("w3_lw", dm[1], 32'hA5A5_A5A5);
    check("w3_lw_valid", 32'(vw[1]), 32'd1);
    op(1, 0, 0, 2'd2, 0, 32'h8, 0, 0, 0, n);
    check("w3_add_ns", 32'(n), 32'd0);
    op(1, 1, 0, 2'd2, 0, 32'h42, 0, 0, 0, n);
    check("w3_bad_ns", 32'(n), 32'd0);
    check("w3_bad_exc", 32'(ex[1]), 32'd1);

    // Two wait states with forwarded store data
    op(2, 0, 1, 2'd2, 0, 32'h20, 32'h0, 1, 32'hDEAD_BEEF, n);
    check("w2_sw_ns", 32'(n), 32'd2);
    op(2, 1, 0, 2'd2, 0, 32'h20, 0, 0, 0, n);
    check("w2_lw_ns", 32'(n), 32'd2);
    check("w2_fwd", dm[2], 32'hDEAD_BEEF);

    // Reset in the middle of a BUSY store
    op(1, 0, 0, 2'd2, 0, 32'h30, 0, 0, 0, n);
    @(negedge clk);
    rd = 0; wr = 1; sz = 2'd2; a = 32'h30; d2 = 32'h77; fs = 0;
    vm[1] = 1'b1;
    @(posedge clk);
    #1;
    check("rstb_busy_stall", 32'(st[1]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstb_valid", 32'(vw[1]), 32'd0);
    check("rstb_alu", aluw[1], 32'd0);
    check("rstb_pc", pcw[1], 32'd0);
    check("rstb_stall", 32'(st[1]), 32'd0);
    vm[1] = 1'b0;
    wr = 0;
    @(negedge clk);
    rst_n = 1'b1;
    op(1, 1, 0, 2'd2, 0, 32'h30, 0, 0, 0, n);
    check("rstb_dropped", dm[1], 32'd0);
    op(1, 1, 0, 2'd2, 0, 32'h40, 0, 0, 0, n);
    check("rstb_cleared_w3", dm[1], 32'd0);
    op(0, 1, 0, 2'd2, 0, 32'h10, 0, 0, 0, n);
    check("rstb_cleared_w0", dm[0], 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
